// File: rtl/spi_reg_bridge_if.sv
// Register-bus handshake between spi_reg_bridge (master) and the
// accelerator register file (slave).
interface spi_reg_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [19:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// Turns decoded SPI frames into single-word register-bus transactions.
// Define SPI_REG_BRIDGE_TIMEOUT_EN to enable the bus_ack timeout and err flag.
module spi_reg_bridge #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [15:0] ERR_WORD    = 16'hDEAD
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [19:0]            addr,
    input  logic [3:0]             status,
    input  logic [15:0]            wdata,
    input  logic                   address_ready,
    input  logic                   data_ready,
    input  logic                   miso_start,
    input  logic                   cs_n_o,
    output logic [15:0]            rdata,
    output logic                   busy,
    output logic                   err,
    spi_reg_bridge_if.master       bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_HOLD,
        WR_WAIT,
        WR_REQ
    } state_t;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 2..255");
    end

    state_t      r_state;
    state_t      w_next;
    logic [19:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_burst;
    logic        r_abort;
    logic        r_err;
    logic        w_req;
    logic        w_to;
    logic        w_done;
    logic        w_ld_addr;
    logic        w_inc;
    logic        w_ld_wd;
    logic        w_ld_rd;

    assign w_req = (r_state == RD_REQ) || (r_state == WR_REQ);

`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
    logic [7:0] r_cnt;

    assign w_to = w_req && !bus.bus_ack
               && (r_cnt == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (w_req && !w_done) ? r_cnt + 8'd1 : 8'd0;
            if (w_to)
                r_err <= 1'b1;
            else if (w_ld_addr)
                r_err <= 1'b0;
        end
    end
`else
    assign w_to  = 1'b0;
    assign r_err = 1'b0;
`endif

    assign w_done = bus.bus_ack || w_to;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_ld_addr = 1'b0;
        w_inc     = 1'b0;
        w_ld_wd   = 1'b0;
        w_ld_rd   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!cs_n_o && address_ready) begin
                    w_ld_addr = 1'b1;
                    w_next    = status[2] ? WR_WAIT : RD_REQ;
                end
            end
            RD_REQ: begin
                if (w_done) begin
                    w_ld_rd = 1'b1;
                    w_next  = (cs_n_o || r_abort) ? IDLE : RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (cs_n_o) begin
                    w_next = IDLE;
                end else if (miso_start) begin
                    w_inc  = r_burst;
                    w_next = r_burst ? RD_REQ : IDLE;
                end
            end
            WR_WAIT: begin
                if (cs_n_o) begin
                    w_next = IDLE;
                end else if (data_ready) begin
                    w_ld_wd = 1'b1;
                    w_next  = WR_REQ;
                end
            end
            WR_REQ: begin
                if (w_done) begin
                    if (cs_n_o || r_abort || w_to || !r_burst) begin
                        w_next = IDLE;
                    end else begin
                        w_inc  = 1'b1;
                        w_next = WR_WAIT;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Remember a frame end seen mid-transaction so it still aborts after ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_burst <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_req && !w_done && (r_abort || cs_n_o);
            if (w_ld_addr) begin
                r_addr  <= addr;
                r_burst <= status[1];
            end else if (w_inc) begin
                r_addr <= r_addr + 20'd1;
            end
            if (w_ld_wd)
                r_wdata <= wdata;
            if (w_ld_rd)
                r_rdata <= w_to ? ERR_WORD : bus.bus_rdata;
        end
    end

    assign bus.bus_req   = w_req;
    assign bus.bus_we    = (r_state == WR_REQ);
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign rdata         = r_rdata;
    assign busy          = (r_state != IDLE);
    assign err           = r_err;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed-vector bench for spi_reg_bridge.
// Timeout vectors run only when SPI_REG_BRIDGE_TIMEOUT_EN is defined.
module tb_spi_reg_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] addr;
    logic [3:0]  status;
    logic [15:0] wdata;
    logic        address_ready;
    logic        data_ready;
    logic        miso_start;
    logic        cs_n_o;
    logic [15:0] rdata;
    logic        busy;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    logic [19:0] wr_a [16];
    logic [15:0] wr_d [16];
    int          n_wr = 0;

    spi_reg_bridge_if bif();

    spi_reg_bridge #(
        .TIMEOUT_CYC (8),
        .ERR_WORD    (16'hDEAD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .addr          (addr),
        .status        (status),
        .wdata         (wdata),
        .address_ready (address_ready),
        .data_ready    (data_ready),
        .miso_start    (miso_start),
        .cs_n_o        (cs_n_o),
        .rdata         (rdata),
        .busy          (busy),
        .err           (err),
        .bus           (bif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && bif.bus_req && bif.bus_we && bif.bus_ack
            && n_wr < 16) begin
            wr_a[n_wr] = bif.bus_addr;
            wr_d[n_wr] = bif.bus_wdata;
            n_wr++;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [19:0] a, input logic [3:0] s);
        addr          = a;
        status        = s;
        address_ready = 1'b1;
        tick();
        address_ready = 1'b0;
    endtask

    task automatic ack(input logic [15:0] d);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = d;
        tick();
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 16'h0;
    endtask

    task automatic pulse_data(input logic [15:0] d);
        wdata      = d;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic pulse_miso();
        miso_start = 1'b1;
        tick();
        miso_start = 1'b0;
    endtask

    task automatic end_frame();
        cs_n_o = 1'b1;
        tick();
        cs_n_o = 1'b0;
    endtask

    int wr0;
    int n;

    initial begin
        reset_n       = 1'b0;
        addr          = '0;
        status        = '0;
        wdata         = '0;
        address_ready = 1'b0;
        data_ready    = 1'b0;
        miso_start    = 1'b0;
        cs_n_o        = 1'b0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = '0;
        tick();
        tick();

        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_req", 32'(bif.bus_req), 32'h0);
        check("rst_we", 32'(bif.bus_we), 32'h0);
        check("rst_addr", 32'(bif.bus_addr), 32'h0);
        check("rst_wdata", 32'(bif.bus_wdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        reset_n = 1'b1;
        tick();

        // single read, ack three cycles after address_ready
        frame(20'h00123, 4'b0000);
        check("rd_req", 32'(bif.bus_req), 32'h1);
        check("rd_we", 32'(bif.bus_we), 32'h0);
        check("rd_addr", 32'(bif.bus_addr), 32'h00123);
        check("rd_busy", 32'(busy), 32'h1);
        tick();
        tick();
        check("rd_req_wait", 32'(bif.bus_req), 32'h1);
        ack(16'hA5C3);
        check("rd_rdata", 32'(rdata), 32'hA5C3);
        check("rd_req_drop", 32'(bif.bus_req), 32'h0);
        check("rd_hold_busy", 32'(busy), 32'h1);
        tick();
        check("rd_rdata_hold", 32'(rdata), 32'hA5C3);
        pulse_miso();
        check("rd_idle", 32'(busy), 32'h0);

        // single write
        wr0 = n_wr;
        frame(20'h00040, 4'b0100);
        check("wr_wait_req", 32'(bif.bus_req), 32'h0);
        check("wr_wait_busy", 32'(busy), 32'h1);
        pulse_data(16'h1234);
        check("wr_req", 32'(bif.bus_req), 32'h1);
        check("wr_we", 32'(bif.bus_we), 32'h1);
        check("wr_addr", 32'(bif.bus_addr), 32'h00040);
        check("wr_wdata", 32'(bif.bus_wdata), 32'h1234);
        tick();
        ack(16'h0);
        check("wr_req_drop", 32'(bif.bus_req), 32'h0);
        tick();
        check("wr_idle", 32'(busy), 32'h0);
        check("wr_count", 32'(n_wr - wr0), 32'd1);
        check("wr_log_a", 32'(wr_a[wr0]), 32'h00040);
        check("wr_log_d", 32'(wr_d[wr0]), 32'h1234);

        // burst write crossing the top of the address space
        wr0 = n_wr;
        frame(20'hFFFFF, 4'b0110);
        pulse_data(16'h0001);
        check("bw_addr0", 32'(bif.bus_addr), 32'hFFFFF);
        ack(16'h0);
        pulse_data(16'h0002);
        check("bw_addr1", 32'(bif.bus_addr), 32'h00000);
        ack(16'h0);
        pulse_data(16'h0003);
        check("bw_addr2", 32'(bif.bus_addr), 32'h00001);
        ack(16'h0);
        check("bw_still_busy", 32'(busy), 32'h1);
        end_frame();
        check("bw_idle", 32'(busy), 32'h0);
        check("bw_count", 32'(n_wr - wr0), 32'd3);
        check("bw_a0", 32'(wr_a[wr0]), 32'hFFFFF);
        check("bw_a1", 32'(wr_a[wr0+1]), 32'h00000);
        check("bw_a2", 32'(wr_a[wr0+2]), 32'h00001);
        check("bw_d2", 32'(wr_d[wr0+2]), 32'h0003);

        // burst read with prefetch
        frame(20'h00010, 4'b0010);
        check("br_addr0", 32'(bif.bus_addr), 32'h00010);
        ack(16'h1111);
        check("br_rdata0", 32'(rdata), 32'h1111);
        pulse_miso();
        check("br_req1", 32'(bif.bus_req), 32'h1);
        check("br_addr1", 32'(bif.bus_addr), 32'h00011);
        ack(16'h2222);
        check("br_rdata1", 32'(rdata), 32'h2222);
        pulse_miso();
        check("br_addr2", 32'(bif.bus_addr), 32'h00012);
        ack(16'h3333);
        check("br_rdata2", 32'(rdata), 32'h3333);
        end_frame();
        check("br_idle", 32'(busy), 32'h0);

        // frame ends while waiting for write data
        wr0 = n_wr;
        frame(20'h00055, 4'b0100);
        end_frame();
        check("ab_idle", 32'(busy), 32'h0);
        pulse_data(16'hBEEF);
        check("ab_no_req", 32'(bif.bus_req), 32'h0);
        check("ab_no_write", 32'(n_wr - wr0), 32'd0);

        // address_ready with cs_n_o high is dropped
        cs_n_o        = 1'b1;
        addr          = 20'h00077;
        status        = 4'b0000;
        address_ready = 1'b1;
        tick();
        address_ready = 1'b0;
        cs_n_o        = 1'b0;
        check("cs_wins_busy", 32'(busy), 32'h0);
        check("cs_wins_req", 32'(bif.bus_req), 32'h0);

        // reset during RD_REQ
        frame(20'h00099, 4'b0000);
        check("mr_req", 32'(bif.bus_req), 32'h1);
        reset_n = 1'b0;
        tick();
        check("mr_req0", 32'(bif.bus_req), 32'h0);
        check("mr_addr0", 32'(bif.bus_addr), 32'h0);
        check("mr_wdata0", 32'(bif.bus_wdata), 32'h0);
        check("mr_rdata0", 32'(rdata), 32'h0);
        check("mr_busy0", 32'(busy), 32'h0);
        check("mr_err0", 32'(err), 32'h0);
        reset_n = 1'b1;
        tick();

`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
        frame(20'h00200, 4'b0000);
        n = 0;
        while (bif.bus_req && n < 20) begin
            n++;
            tick();
        end
        check("to_cycles", 32'(n), 32'd8);
        check("to_err", 32'(err), 32'h1);
        check("to_rdata", 32'(rdata), 32'hDEAD);
        check("to_hold", 32'(busy), 32'h1);
        end_frame();
        check("to_err_sticky", 32'(err), 32'h1);
        frame(20'h00201, 4'b0000);
        check("to_err_clr", 32'(err), 32'h0);
        ack(16'h4242);
        end_frame();
`else
        frame(20'h00200, 4'b0000);
        n = 0;
        while (bif.bus_req && n < 20) begin
            n++;
            tick();
        end
        check("nto_waits", 32'(n), 32'd20);
        check("nto_err", 32'(err), 32'h0);
        ack(16'h4242);
        check("nto_rdata", 32'(rdata), 32'h4242);
        end_frame();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Converts decoded SPI frames into single-word transactions on the accelerator's internal register bus. It sits directly downstream of `spi_data_path`, consuming `addr`, `status`, `wdata`, `address_ready`, `data_ready`, `miso_start` and `cs_n_o`. It returns read data on `rdata` early enough for the SPI path to shift it out on MISO. Burst frames auto-increment the bus address per data word.

## Interface
- `TIMEOUT_CYC`, default 64: bus cycles to wait for `bus_ack` before aborting (range 2–255).
- `ERR_WORD`, default 16'hDEAD: word returned on `rdata` after a timed-out read.

Ports:
- `clk` in 1: system clock; single clock domain; all inputs are synchronous to it.
- `reset_n` in 1: reset; **synchronous and active-low**.
- `addr` in 20: frame word address from the SPI path.
- `status` in 4: frame control. `[2]` = write (1) or read (0). `[1]` = burst. `[3]` and `[0]` are reserved and ignored.
- `wdata` in 16: write data from the SPI path.
- `address_ready` in 1: one-cycle pulse; `addr` and `status` are valid.
- `data_ready` in 1: one-cycle pulse; `wdata` is valid.
- `miso_start` in 1: one-cycle pulse; the SPI path has latched `rdata` and begun shifting.
- `cs_n_o` in 1: chip select (high = frame ended).
- `rdata` out 16: read word to the SPI path.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write enable.
- `bus_addr` out 20: bus word address.
- `bus_wdata` out 16: bus write data.
- `bus_ack` in 1: bus completion.
- `bus_rdata` in 16: bus read data, valid while `bus_ack` is high.
- `busy` out 1: FSM is not in IDLE.
- `err` out 1: sticky timeout flag; cleared on the next `address_ready`.

## Operation
FSM states: IDLE, RD_REQ, RD_HOLD, WR_WAIT, WR_REQ.
- **IDLE**, on `address_ready`:
  - Latch `addr` into `bus_addr`, and `status[2:1]` into internal `we_q` and `burst_q`.
  - Clear `err`.
  - Go to RD_REQ if `status[2]=0`, otherwise WR_WAIT.
- **RD_REQ**:
  - `bus_req=1`, `bus_we=0`.
  - On `bus_ack`: `rdata<=bus_rdata`, then go to RD_HOLD.
- **RD_HOLD**:
  - On `miso_start`: if `burst_q`, do `bus_addr<=bus_addr+1` and go to RD_REQ (prefetch the next word); otherwise go to IDLE.
- **WR_WAIT**:
  - On `data_ready`: `bus_wdata<=wdata`, then go to WR_REQ.
- **WR_REQ**:
  - `bus_req=1`, `bus_we=1`.
  - On `bus_ack`: if `burst_q`, do `bus_addr<=bus_addr+1` and go to WR_WAIT; otherwise go to IDLE.

Rules:
- `bus_addr`, `bus_we` and `bus_wdata` are held stable while `bus_req=1`.
- `bus_req` drops in the cycle after `bus_ack` is sampled.
- Address increment is modulo 2^20: 20'hFFFFF wraps to 20'h00000.
- `cs_n_o=1` in IDLE, RD_HOLD or WR_WAIT: go to IDLE next cycle.
- `cs_n_o=1` in RD_REQ or WR_REQ: the outstanding transaction completes (ack or timeout), then the FSM goes to IDLE.
- `address_ready` outside IDLE is ignored.
- `data_ready` outside WR_WAIT is ignored.
- `miso_start` outside RD_HOLD is ignored.
- `rdata` holds its value between reads.
- `busy` is high in every state except IDLE.

## Timing
- Reset values:
  - `rdata`=16'h0000, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `busy`=0, `err`=0.
  - FSM in IDLE; timeout counter 0.
- `address_ready` at cycle T (read):
  - `bus_req=1` from T+1.
  - Ack sampled at cycle A sets `rdata` valid at A+1; `bus_req=0` at A+1.
  - The earliest `bus_ack` honoured is T+1, i.e. the first cycle `bus_req` is high.
- `data_ready` at T: `bus_req=1` and `bus_we=1` from T+1.
- Burst read: `miso_start` at T gives the incremented `bus_addr` and `bus_req=1` at T+1.
- Reset asserted mid-transaction: all outputs return to their reset values on the next clock edge. `bus_req` drops even without an ack.
- `address_ready` and `cs_n_o=1` in the same IDLE cycle: `cs_n_o` wins; the FSM stays in IDLE.

## Configuration
- `SPI_REG_BRIDGE_TIMEOUT_EN` **defined**:
  - An 8-bit counter runs while `bus_req=1`.
  - When the counter reaches `TIMEOUT_CYC` without `bus_ack`, drop `bus_req` and set `err=1`.
  - A timed-out read loads `rdata<=ERR_WORD`, then the FSM proceeds as if acked.
  - A timed-out write goes to IDLE, aborting any burst.
- **Not defined**: no counter; the FSM waits for `bus_ack` indefinitely; `err` is tied to 0.

## Test plan
- Single read:
  - Stimulus: `addr`=20'h00123, `status`=4'b0000, `address_ready` pulse; `bus_ack` 3 cycles later with `bus_rdata`=16'hA5C3.
  - Response: `bus_addr`=20'h00123, `bus_we=0`, `rdata`=16'hA5C3; IDLE after `miso_start`.
- Single write:
  - Stimulus: `status`=4'b0100, `addr`=20'h00040, then `data_ready` with `wdata`=16'h1234; ack after 1 cycle.
  - Response: one bus write of 16'h1234 to 20'h00040; `busy=0` 2 cycles after the ack.
- Burst write with wrap:
  - Stimulus: `status`=4'b0110, `addr`=20'hFFFFF, three `data_ready` pulses (16'h0001, 16'h0002, 16'h0003).
  - Response: writes go to 20'hFFFFF, 20'h00000 and 20'h00001 respectively.
- Burst read prefetch:
  - Stimulus: `status`=4'b0010, `addr`=20'h00010, two `miso_start` pulses.
  - Response: reads of 20'h00010, then 20'h00011 issued the cycle after the first `miso_start`, then 20'h00012.
- Timeout (macro defined, `TIMEOUT_CYC`=8):
  - Stimulus: read with `bus_ack` held 0.
  - Response: `bus_req` drops after 8 cycles, `err=1`, `rdata`=16'hDEAD. The next `address_ready` clears `err`.
- Abort:
  - Stimulus: `cs_n_o` rises in WR_WAIT.
  - Response: IDLE next cycle, no bus write.
  - Stimulus: `reset_n` low during RD_REQ.
  - Response: `bus_req=0` and all outputs at their reset values after one edge.
